// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: ID decode fields in, EX operand selects, stall and stall count out
interface fwd_hazard_unit_if #(parameter int REG_ADDR_W = 5, parameter int CNT_W = 16);
  logic [REG_ADDR_W-1:0] id_rs, id_rt, id_dst;
  logic id_uses_rt, id_reg_write, id_mem_read, flush;
  logic [1:0] ex_fwd_a, ex_fwd_b;
  logic stall;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output id_rs, id_rt, id_uses_rt, id_dst, id_reg_write, id_mem_read, flush,
    input ex_fwd_a, ex_fwd_b, stall, stall_count
  );
  modport slave (
    input id_rs, id_rt, id_uses_rt, id_dst, id_reg_write, id_mem_read, flush,
    output ex_fwd_a, ex_fwd_b, stall, stall_count
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX/MEM/WB destination tracking, operand forwarding selects and load-use stall
module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  fwd_hazard_unit_if.slave bus
);
  logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
  logic ex_rw, ex_mr, mem_rw, wb_rw, hazard, bubble;
  logic [CNT_W-1:0] cnt;
  assign hazard = ex_mr && ex_dst != '0 &&
                  (ex_dst == bus.id_rs || (bus.id_uses_rt && ex_dst == bus.id_rt));
  assign bus.stall = hazard && !bus.flush;
  assign bubble = bus.stall || bus.flush;
  assign bus.stall_count = cnt;
  // MEM is checked first so the youngest producer wins; $0 is never forwarded
  assign bus.ex_fwd_a = (mem_rw && mem_dst != '0 && mem_dst == ex_rs) ? 2'b10 :
                        (wb_rw && wb_dst != '0 && wb_dst == ex_rs) ? 2'b01 : 2'b00;
  assign bus.ex_fwd_b = (mem_rw && mem_dst != '0 && mem_dst == ex_rt) ? 2'b10 :
                        (wb_rw && wb_dst != '0 && wb_dst == ex_rt) ? 2'b01 : 2'b00;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs <= '0;
      ex_rt <= '0;
      ex_dst <= '0;
      ex_rw <= 1'b0;
      ex_mr <= 1'b0;
      mem_dst <= '0;
      mem_rw <= 1'b0;
      wb_dst <= '0;
      wb_rw <= 1'b0;
      cnt <= '0;
    end else begin
      ex_rs <= bubble ? '0 : bus.id_rs;
      ex_rt <= bubble ? '0 : bus.id_rt;
      ex_dst <= bubble ? '0 : bus.id_dst;
      ex_rw <= bubble ? 1'b0 : bus.id_reg_write;
      ex_mr <= bubble ? 1'b0 : bus.id_mem_read;
      mem_dst <= ex_dst;
      mem_rw <= ex_rw;
      wb_dst <= mem_dst;
      wb_rw <= mem_rw;
      if (bus.stall && !(&cnt)) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed and random checks against an instruction-record pipeline model
module tb_fwd_hazard_unit;
  localparam int AW = 5;
  localparam int CW = 10;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fwd_hazard_unit_if #(.REG_ADDR_W(AW), .CNT_W(CW)) bus ();
  fwd_hazard_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct packed {
    logic [AW-1:0] rs, rt, dst;
    logic uses_rt, rw, mr;
  } ins_t;
  ins_t ex, mem, wb, cur;
  logic cur_flush;
  int m_cnt = 0;
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  function automatic logic [1:0] fsel(input logic [AW-1:0] r);
    ins_t prod [2];
    logic [1:0] code [2];
    prod[0] = mem;
    prod[1] = wb;
    code[0] = 2'b10;
    code[1] = 2'b01;
    for (int i = 0; i < 2; i++)
      if (prod[i].rw && prod[i].dst != 0 && prod[i].dst == r) return code[i];
    return 2'b00;
  endfunction
  function automatic logic m_stall();
    return !cur_flush && ex.mr && ex.dst != 0 &&
           (ex.dst == cur.rs || (cur.uses_rt && ex.dst == cur.rt));
  endfunction
  task automatic drive(input int rs, input int rt, input bit ur, input int dst,
                       input bit rw, input bit mr, input bit fl = 1'b0);
    cur = '{rs: AW'(rs), rt: AW'(rt), dst: AW'(dst), uses_rt: ur, rw: rw, mr: mr};
    cur_flush = fl;
    bus.id_rs = cur.rs;
    bus.id_rt = cur.rt;
    bus.id_uses_rt = ur;
    bus.id_dst = cur.dst;
    bus.id_reg_write = rw;
    bus.id_mem_read = mr;
    bus.flush = fl;
    #1;
  endtask
  task automatic nop();
    drive(0, 0, 0, 0, 0, 0);
  endtask
  task automatic model_reset();
    ex = '0;
    mem = '0;
    wb = '0;
    m_cnt = 0;
  endtask
  task automatic tick();
    logic s;
    s = m_stall();
    chk("fwd_a", 32'(bus.ex_fwd_a), 32'(fsel(ex.rs)));
    chk("fwd_b", 32'(bus.ex_fwd_b), 32'(fsel(ex.rt)));
    chk("stall", 32'(bus.stall), 32'(s));
    chk("stall_count", 32'(bus.stall_count), 32'(m_cnt));
    @(posedge clk);
    wb = mem;
    mem = ex;
    ex = (s || cur_flush) ? '0 : cur;
    if (s && m_cnt < CMAX) m_cnt++;
    @(negedge clk);
  endtask
  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      nop();
      tick();
    end
  endtask
  initial begin
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive($urandom_range(31), $urandom_range(31), 1'($urandom), $urandom_range(31),
            1'($urandom), 1'($urandom), 1'($urandom));
      chk("rst_fwd_a", 32'(bus.ex_fwd_a), 0);
      chk("rst_fwd_b", 32'(bus.ex_fwd_b), 0);
      chk("rst_stall", 32'(bus.stall), 0);
      chk("rst_count", 32'(bus.stall_count), 0);
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b1;
    nops(2);
    // EX/MEM forward
    drive(1, 2, 1, 3, 1, 0); tick();
    drive(3, 5, 1, 4, 1, 0); tick();
    nop();
    chk("exmem_a", 32'(bus.ex_fwd_a), 2);
    chk("exmem_b", 32'(bus.ex_fwd_b), 0);
    tick();
    nops(3);
    // MEM/WB forward
    drive(1, 2, 1, 3, 1, 0); tick();
    drive(9, 10, 1, 11, 1, 0); tick();
    drive(7, 3, 1, 6, 1, 0); tick();
    nop();
    chk("memwb_a", 32'(bus.ex_fwd_a), 0);
    chk("memwb_b", 32'(bus.ex_fwd_b), 1);
    tick();
    nops(3);
    // youngest producer wins
    drive(1, 2, 1, 3, 1, 0); tick();
    drive(4, 5, 1, 3, 1, 0); tick();
    drive(3, 3, 1, 8, 1, 0); tick();
    nop();
    chk("prio_a", 32'(bus.ex_fwd_a), 2);
    chk("prio_b", 32'(bus.ex_fwd_b), 2);
    tick();
    nops(3);
    // $0 never forwarded
    drive(1, 2, 1, 0, 1, 0); tick();
    drive(0, 0, 1, 9, 1, 0); tick();
    nop();
    chk("zero_a", 32'(bus.ex_fwd_a), 0);
    chk("zero_b", 32'(bus.ex_fwd_b), 0);
    tick();
    nops(3);
    // load-use: one stall cycle, then forward from WB
    drive(1, 0, 0, 2, 1, 1); tick();
    drive(2, 1, 1, 4, 1, 0);
    chk("lu_stall", 32'(bus.stall), 1);
    tick();
    chk("lu_stall_drop", 32'(bus.stall), 0);
    chk("lu_count", 32'(bus.stall_count), 1);
    tick();
    nop();
    chk("lu_fwd_a", 32'(bus.ex_fwd_a), 1);
    tick();
    nops(3);
    // rt match but rt unused: no stall
    drive(1, 0, 0, 2, 1, 1); tick();
    drive(5, 2, 0, 4, 1, 0);
    chk("lu_no_rt", 32'(bus.stall), 0);
    tick();
    nops(3);
    // flush beats stall; killed instruction leaves a non-writing bubble
    drive(1, 0, 0, 2, 1, 1); tick();
    drive(2, 1, 1, 4, 1, 0, 1);
    chk("flush_stall", 32'(bus.stall), 0);
    tick();
    drive(4, 4, 1, 7, 1, 0); tick();
    nop();
    chk("flush_bubble", 32'(bus.ex_fwd_a), 0);
    tick();
    nops(3);
    // asynchronous reset during an active stall
    drive(1, 0, 0, 2, 1, 1); tick();
    drive(2, 2, 1, 4, 1, 0);
    chk("pre_rst_stall", 32'(bus.stall), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_stall", 32'(bus.stall), 0);
    chk("async_rst_fwd_a", 32'(bus.ex_fwd_a), 0);
    chk("async_rst_count", 32'(bus.stall_count), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    nops(2);
    // random traffic over a small register set to provoke matches
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(7), $urandom_range(7), 1'($urandom), $urandom_range(7),
            1'($urandom), ($urandom_range(3) == 0), ($urandom_range(7) == 0));
      tick();
    end
    // saturation: self-dependent load stalls every other cycle
    for (int i = 0; i < 2 * CMAX + 40; i++) begin
      drive(2, 0, 0, 2, 1, 1);
      tick();
    end
    chk("sat_count", 32'(bus.stall_count), CMAX);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
